ysyx_040750_if_fetch: RTL and testbench

YSYX_040750_IF_FETCH -- requirements
Module: ysyx_040750_if_fetch

---
 rtl/ysyx_040750_if_fetch_pkg.sv | 19 +
 rtl/ysyx_040750_if_pc_gen.sv | 66 ++++++
 rtl/ysyx_040750_if_fetch.sv | 88 ++++++++
 tb/tb_ysyx_040750_if_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_040750_if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// reset fetch address and the NOP used to fill the instruction register.
package ysyx_040750_if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_040750_if_pc_gen.sv
// Fetch address bookkeeping: current pc, pending redirect target and the
// kill flag that marks an in-flight response as belonging to a dead path.
module ysyx_040750_if_pc_gen
  import ysyx_040750_if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         I_sys_clk,
  input  logic         I_rst,
  input  fetch_state_e i_state,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_pc,
  input  logic         i_imem_ready,
  input  logic         i_imem_rvalid,
  input  logic         i_allowin,
  output logic [31:0]  o_pc,
  output logic         o_kill
);

  logic [31:0] r_pc;
  logic [31:0] r_pc_next;
  logic        r_kill;

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_pc      <= RESET_PC;
      r_pc_next <= RESET_PC;
      r_kill    <= 1'b0;
    end else begin
      case (i_state)
        ST_IDLE: begin
          if (i_redirect) r_pc <= i_redirect_pc;
        end
        ST_REQ: begin
          // An unaccepted request must keep its address, so the target is
          // parked in r_pc_next and applied once the killed response drains.
          if (i_redirect) begin
            r_pc_next <= i_redirect_pc;
            r_kill    <= 1'b1;
            if (i_imem_ready) r_pc <= i_redirect_pc;
          end
        end
        ST_WAIT: begin
          if (i_imem_rvalid) begin
            r_kill <= 1'b0;
            if (i_redirect)  r_pc <= i_redirect_pc;
            else if (r_kill) r_pc <= r_pc_next;
          end else if (i_redirect) begin
            r_pc      <= i_redirect_pc;
            r_pc_next <= i_redirect_pc;
            r_kill    <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_redirect)     r_pc <= i_redirect_pc;
          else if (i_allowin) r_pc <= seq_pc(r_pc);
        end
        default: ;
      endcase
    end
  end

  assign o_pc   = r_pc;
  assign o_kill = r_kill;

endmodule

// File: rtl/ysyx_040750_if_fetch.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// holds the fetched word until the IF/ID register accepts it.
module ysyx_040750_if_fetch
  import ysyx_040750_if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  input  logic        I_timer_intr,
  input  logic        I_IF_ID_allowin,
  output logic        O_IF_ID_valid,
  output logic [31:0] O_pc,
  output logic [31:0] O_inst,
  output logic        O_timer_intr,
  output logic        O_IF_ID_jmp,
  output logic        O_imem_req,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_ready,
  input  logic        I_imem_rvalid,
  input  logic [31:0] I_imem_rdata
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic         r_timer_intr;
  logic [31:0]  w_pc;
  logic         w_kill;

  ysyx_040750_if_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .I_sys_clk     (I_sys_clk),
    .I_rst         (I_rst),
    .i_state       (r_state),
    .i_redirect    (I_redirect),
    .i_redirect_pc (I_redirect_pc),
    .i_imem_ready  (I_imem_ready),
    .i_imem_rvalid (I_imem_rvalid),
    .i_allowin     (I_IF_ID_allowin),
    .o_pc          (w_pc),
    .o_kill        (w_kill)
  );

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_inst       <= NOP_INST;
      r_timer_intr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ: begin
          if (I_imem_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (I_imem_rvalid) begin
            if (w_kill || I_redirect) begin
              r_state <= ST_REQ;
            end else begin
              r_state      <= ST_HOLD;
              r_pc         <= w_pc;
              r_inst       <= I_imem_rdata;
              r_timer_intr <= I_timer_intr;
            end
          end
        end
        ST_HOLD: begin
          if (I_redirect || I_IF_ID_allowin) r_state <= ST_REQ;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign O_IF_ID_valid = (r_state == ST_HOLD);
  assign O_imem_req    = (r_state == ST_REQ);
  assign O_imem_addr   = w_pc;
  assign O_pc          = r_pc;
  assign O_inst        = r_inst;
  assign O_timer_intr  = r_timer_intr;
  assign O_IF_ID_jmp   = I_redirect && O_IF_ID_valid;

endmodule

// File: tb/tb_ysyx_040750_if_fetch.sv
// Directed bench for the fetch stage: one row per clock cycle of inputs and
// the outputs expected during that cycle, plus reset and pc-wrap sequences.
module tb_ysyx_040750_if_fetch;

  localparam logic [31:0] B   = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        timer_intr;
  logic        allowin;
  logic        valid;
  logic [31:0] opc;
  logic [31:0] inst;
  logic        otmr;
  logic        jmp;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  ysyx_040750_if_fetch #(
    .RESET_PC(32'h8000_0000)
  ) dut (
    .I_sys_clk       (clk),
    .I_rst           (rst),
    .I_redirect      (redirect),
    .I_redirect_pc   (redirect_pc),
    .I_timer_intr    (timer_intr),
    .I_IF_ID_allowin (allowin),
    .O_IF_ID_valid   (valid),
    .O_pc            (opc),
    .O_inst          (inst),
    .O_timer_intr    (otmr),
    .O_IF_ID_jmp     (jmp),
    .O_imem_req      (req),
    .O_imem_addr     (addr),
    .I_imem_ready    (ready),
    .I_imem_rvalid   (rvalid),
    .I_imem_rdata    (rdata)
  );

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        alw;
    logic        tmr;
    logic        evld;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        etmr;
    logic        ejmp;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(
    input logic rd, input logic [31:0] rpc, input logic rdy, input logic rv,
    input logic [31:0] rdat, input logic alw, input logic tmr,
    input logic evld, input logic ereq, input logic [31:0] eaddr,
    input logic [31:0] epc, input logic [31:0] einst, input logic etmr,
    input logic ejmp);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rdata = rdat;
    v.alw = alw; v.tmr = tmr; v.evld = evld; v.ereq = ereq;
    v.eaddr = eaddr; v.epc = epc; v.einst = einst; v.etmr = etmr;
    v.ejmp = ejmp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic rv,
                       input logic [31:0] rdat, input logic alw,
                       input logic tmr);
    redirect = rd; redirect_pc = rpc; ready = rdy; rvalid = rv;
    rdata = rdat; allowin = alw; timer_intr = tmr;
  endtask

  initial begin
    // Rows: inputs for the cycle, then outputs expected during that cycle.
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NOP, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B, 0, NOP, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 32'h1111_1111, 0, 1,  0, 0, 0, 0, NOP, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 0,  1, 0, 0, B, 32'h1111_1111, 1, 0);
    vecs[4]  = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B + 32'h4, B, 32'h1111_1111, 1, 0);
    vecs[5]  = mk(0, 0, 0, 1, 32'h2222_2222, 0, 0,  0, 0, 0, B, 32'h1111_1111, 1, 0);
    for (int i = 6; i <= 10; i++)
      vecs[i] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 0,  1, 0, 0, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, B + 32'h8, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[13] = mk(1, B + 32'h300, 0, 0, 0, 0, 0,  0, 1, B + 32'h8, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[14] = mk(1, B + 32'h400, 0, 0, 0, 0, 0,  0, 1, B + 32'h8, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B + 32'h8, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 32'h3333_3333, 0, 0,  0, 0, 0, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B + 32'h400, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[18] = mk(1, B + 32'h100, 0, 0, 0, 0, 0,  0, 0, 0, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[19] = mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0,  0, 0, 0, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[20] = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B + 32'h100, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[21] = mk(0, 0, 0, 1, 32'h4444_4444, 0, 0,  0, 0, 0, B + 32'h4, 32'h2222_2222, 0, 0);
    vecs[22] = mk(1, B + 32'h200, 0, 0, 0, 1, 0,  1, 0, 0, B + 32'h100, 32'h4444_4444, 0, 1);
    vecs[23] = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B + 32'h200, B + 32'h100, 32'h4444_4444, 0, 0);
    vecs[24] = mk(1, B + 32'h500, 0, 1, 32'h5555_5555, 0, 0,  0, 0, 0, B + 32'h100, 32'h4444_4444, 0, 0);
    vecs[25] = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B + 32'h500, B + 32'h100, 32'h4444_4444, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, B + 32'h100, 32'h4444_4444, 0, 0);
    vecs[27] = mk(0, 0, 0, 1, 32'h6666_6666, 0, 1,  0, 0, 0, B + 32'h100, 32'h4444_4444, 0, 0);
    vecs[28] = mk(1, B + 32'h600, 0, 0, 0, 0, 0,  1, 0, 0, B + 32'h500, 32'h6666_6666, 1, 1);
    vecs[29] = mk(0, 0, 1, 0, 0, 0, 0,  0, 1, B + 32'h600, B + 32'h500, 32'h6666_6666, 1, 0);
    vecs[30] = mk(0, 0, 0, 1, 32'h7777_7777, 0, 0,  0, 0, 0, B + 32'h500, 32'h6666_6666, 1, 0);
    vecs[31] = mk(0, 0, 0, 0, 0, 1, 0,  1, 0, 0, B + 32'h600, 32'h7777_7777, 0, 0);
    vecs[32] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, B + 32'h604, B + 32'h600, 32'h7777_7777, 0, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst req",   {31'd0, req},   32'd0);
    chk("rst pc",    opc,            32'd0);
    chk("rst inst",  inst,           NOP);
    chk("rst tmr",   {31'd0, otmr},  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rv, vecs[i].rdata,
            vecs[i].alw, vecs[i].tmr);
      #1;
      chk($sformatf("row%0d valid", i), {31'd0, valid}, {31'd0, vecs[i].evld});
      chk($sformatf("row%0d req", i),   {31'd0, req},   {31'd0, vecs[i].ereq});
      chk($sformatf("row%0d jmp", i),   {31'd0, jmp},   {31'd0, vecs[i].ejmp});
      chk($sformatf("row%0d pc", i),    opc,            vecs[i].epc);
      chk($sformatf("row%0d inst", i),  inst,           vecs[i].einst);
      chk($sformatf("row%0d tmr", i),   {31'd0, otmr},  {31'd0, vecs[i].etmr});
      if (vecs[i].ereq)
        chk($sformatf("row%0d addr", i), addr, vecs[i].eaddr);
      step();
    end

    // Reset while a response is outstanding.
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wrst valid", {31'd0, valid}, 32'd0);
    chk("wrst req",   {31'd0, req},   32'd0);
    chk("wrst pc",    opc,            32'd0);
    chk("wrst inst",  inst,           NOP);
    step();
    chk("wrst req2",  {31'd0, req},   32'd1);
    chk("wrst addr",  addr,           B);

    // Redirect in IDLE, then sequential pc wraps past the top of memory.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    step();
    chk("wrap req",   {31'd0, req}, 32'd1);
    chk("wrap addr0", addr,         32'hFFFF_FFFC);
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 32'h8888_8888, 0, 0);
    step();
    chk("wrap valid", {31'd0, valid}, 32'd1);
    chk("wrap pc",    opc,            32'hFFFF_FFFC);
    chk("wrap inst",  inst,           32'h8888_8888);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("wrap req2",  {31'd0, req},   32'd1);
    chk("wrap addr1", addr,           32'h0000_0000);
    chk("wrap vld2",  {31'd0, valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
